// File: rtl/aes_pkg.sv
// AES byte-substitution tables and lookup helpers.
// Shared by the SubBytes pipeline and the key-expansion SubWord path.
package aes_pkg;

  localparam int BYTE_W = 8;

  // Entry 0 is the leftmost byte of each table.
  localparam logic [0:255][BYTE_W-1:0] AES_SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][BYTE_W-1:0] AES_SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [BYTE_W-1:0] sbox_fwd(
    input logic [BYTE_W-1:0] b
  );
    return AES_SBOX_FWD[b];
  endfunction

  function automatic logic [BYTE_W-1:0] sbox_inv(
    input logic [BYTE_W-1:0] b
  );
    return AES_SBOX_INV[b];
  endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// One combinational S-box lane: forward, or inverse when inv is set.
// Without SUPPORT_INV only the forward table is built.
module aes_sbox_lane
  import aes_pkg::*;
#(
  parameter bit SUPPORT_INV = 1'b1
) (
  input  logic [BYTE_W-1:0] data,
  input  logic              inv,
  output logic [BYTE_W-1:0] result
);

  if (SUPPORT_INV) begin : g_both
    assign result = inv ? sbox_inv(data) : sbox_fwd(data);
  end else begin : g_fwd
    assign result = sbox_fwd(data);
  end

endmodule

// File: rtl/sub_bytes_pipe.sv
// Elastic pipelined SubBytes engine, LANES independent byte lanes.
// Each beat picks forward or inverse substitution on its own.
module sub_bytes_pipe
  import aes_pkg::*;
#(
  parameter int LANES       = 16,
  parameter int PIPE_STAGES = 2,
  parameter bit SUPPORT_INV = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BYTE_W*LANES-1:0] in_data,
  input  logic                    in_inv,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BYTE_W*LANES-1:0] out_data,
  output logic                    out_inv
);

  localparam int W    = BYTE_W * LANES;
  localparam int LAST = PIPE_STAGES - 1;

  if (PIPE_STAGES < 1 || PIPE_STAGES > 2) begin : g_bad_stages
    $error("sub_bytes_pipe: PIPE_STAGES must be 1 or 2");
  end
  if (LANES < 1 || LANES > 16) begin : g_bad_lanes
    $error("sub_bytes_pipe: LANES must be 1..16");
  end

  logic [PIPE_STAGES-1:0] v;
  logic [PIPE_STAGES-1:0] adv;
  logic [PIPE_STAGES-1:0] i_q;
  logic [W-1:0]           d_q [PIPE_STAGES];

  logic [PIPE_STAGES-1:0] src_v;
  logic [PIPE_STAGES-1:0] src_i;
  logic [W-1:0]           src_d [PIPE_STAGES];

  logic [W-1:0] lk_in;
  logic [W-1:0] lk_out;
  logic         lk_inv;
  logic         inv_sel;

  assign inv_sel = SUPPORT_INV ? in_inv : 1'b0;

  // Stage 0 holds raw bytes when there are two stages.
  if (PIPE_STAGES == 2) begin : g_two
    assign lk_in    = d_q[0];
    assign lk_inv   = i_q[0];
    assign src_d[0] = in_data;
    assign src_i[0] = inv_sel;
    assign src_d[1] = lk_out;
    assign src_i[1] = i_q[0];
    assign src_v    = {v[0], in_valid};
  end else begin : g_one
    assign lk_in    = in_data;
    assign lk_inv   = inv_sel;
    assign src_d[0] = lk_out;
    assign src_i[0] = inv_sel;
    assign src_v    = in_valid;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_sbox_lane #(
      .SUPPORT_INV(SUPPORT_INV)
    ) u_lane (
      .data  (lk_in[l*BYTE_W +: BYTE_W]),
      .inv   (lk_inv),
      .result(lk_out[l*BYTE_W +: BYTE_W])
    );
  end

  // A stage may move if any stage from it to the tail is empty.
  always_comb begin
    logic full;
    full = 1'b1;
    adv  = '0;
    for (int k = LAST; k >= 0; k--) begin
      full   = full && v[k];
      adv[k] = out_ready || !full;
    end
  end

  assign in_ready = adv[0] && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      v   <= '0;
      i_q <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) d_q[k] <= '0;
    end else begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        if (adv[k]) begin
          v[k]   <= src_v[k];
          i_q[k] <= src_i[k];
          d_q[k] <= src_d[k];
        end
      end
    end
  end

  assign out_valid = v[LAST];
  assign out_data  = d_q[LAST];
  assign out_inv   = i_q[LAST];

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// Scoreboard bench: 16-lane two-stage engine with inverse table, plus
// a 4-lane single-stage forward-only engine sharing the same stimulus.
module tb_sub_bytes_pipe;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         in_inv = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic         out_inv;

  logic         b_in_ready;
  logic         b_out_valid;
  logic [31:0]  b_out_data;
  logic         b_out_inv;

  always #5 clk = ~clk;

  sub_bytes_pipe #(
    .LANES(16), .PIPE_STAGES(2), .SUPPORT_INV(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_inv(in_inv),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_inv(out_inv)
  );

  sub_bytes_pipe #(
    .LANES(4), .PIPE_STAGES(1), .SUPPORT_INV(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data[31:0]), .in_inv(in_inv),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_inv(b_out_inv)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference S-box built from GF(2^8) inversion plus the affine map.
  logic [7:0] fwd_m [256];
  logic [7:0] inv_m [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic build_model();
    logic [7:0] iv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      iv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
      s = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
      fwd_m[x] = s;
      inv_m[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] sub(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[8*i +: 8] = inv ? inv_m[d[8*i +: 8]] : fwd_m[d[8*i +: 8]];
    return r;
  endfunction

  typedef struct packed {
    logic [127:0] d;
    logic         i;
  } exp_t;

  exp_t        q_a [$];
  logic [31:0] q_b [$];

  always @(negedge clk) begin
    exp_t e;
    logic [127:0] t;
    if (rst) begin
      q_a.delete();
      q_b.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q_a.size() == 0) check("a_spurious", out_valid, 1'b0);
        else begin
          e = q_a.pop_front();
          check("a_data", out_data, e.d);
          check("a_inv", out_inv, e.i);
        end
      end
      if (in_valid && in_ready) begin
        e.d = sub(in_data, in_inv);
        e.i = in_inv;
        q_a.push_back(e);
      end
      if (b_out_valid && out_ready) begin
        if (q_b.size() == 0) check("b_spurious", b_out_valid, 1'b0);
        else begin
          check("b_data", b_out_data, q_b.pop_front());
          check("b_inv", b_out_inv, 1'b0);
        end
      end
      if (in_valid && b_in_ready) begin
        t = sub({96'h0, in_data[31:0]}, 1'b0);
        q_b.push_back(t[31:0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int           nb;
  int           n_out;
  int           last_t;
  bit           stalled;
  logic [127:0] held;

  initial begin
    build_model();

    step();
    @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_ready", in_ready, 1'b0);
    check("rst_data", out_data, '0);
    check("rst_inv", out_inv, 1'b0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready_rel", in_ready, 1'b1);

    // Forward then inverse beat back to back.
    step();
    in_valid = 1'b1; in_data = 128'hFF530100; in_inv = 1'b0;
    @(negedge clk);
    check("fwd_lat0", out_valid, 1'b0);
    check("b_lat0", b_out_valid, 1'b0);
    step();
    in_data = 128'h16ED7C63; in_inv = 1'b1;
    @(negedge clk);
    check("fwd_lat1", out_valid, 1'b0);
    check("b_fwd_valid", b_out_valid, 1'b1);
    check("b_fwd_data", b_out_data, 32'h16ED7C63);
    step();
    in_valid = 1'b0; in_inv = 1'b0;
    @(negedge clk);
    check("fwd_valid", out_valid, 1'b1);
    check("fwd_data", out_data[31:0], 32'h16ED7C63);
    check("fwd_inv", out_inv, 1'b0);
    check("b_inv_ignored", b_out_data[7:0], 8'hFB);
    check("b_inv_zero", b_out_inv, 1'b0);
    step();
    @(negedge clk);
    check("inv_data", out_data[31:0], 32'hFF530100);
    check("inv_inv", out_inv, 1'b1);
    check("inv_hi", out_data[127:120], 8'h52);

    // Interleaved tables on consecutive beats.
    for (int i = 0; i < 8; i++) begin
      step();
      in_valid = 1'b1;
      in_inv = i[0];
      in_data = {$urandom, $urandom, $urandom, $urandom};
    end

    // All byte values forward, then their images back through inverse.
    for (int b = 0; b < 16; b++) begin
      step();
      in_inv = 1'b0;
      for (int i = 0; i < 16; i++) in_data[8*i +: 8] = 8'(b * 16 + i);
    end
    for (int b = 0; b < 16; b++) begin
      step();
      in_inv = 1'b1;
      for (int i = 0; i < 16; i++) in_data[8*i +: 8] = fwd_m[b * 16 + i];
    end
    step();
    in_valid = 1'b0;
    repeat (4) step();

    // Backpressure: six beats, downstream stalled in cycles 3..5.
    nb = 0; n_out = 0; last_t = -1; stalled = 1'b0; held = '0;
    for (int t = 0; t < 16; t++) begin
      step();
      out_ready = !(t >= 3 && t <= 5);
      in_valid = (nb < 6);
      in_inv = nb[0];
      in_data = {4{32'hA5000000 | 32'(nb)}};
      @(negedge clk);
      if (t == 3) check("bp_ready_low", in_ready, 1'b0);
      if (stalled) check("bp_stable", out_data, held);
      stalled = out_valid && !out_ready;
      held = out_data;
      if (out_valid && out_ready) begin
        n_out++;
        last_t = t;
      end
      if (in_valid && in_ready) nb++;
    end
    check("bp_accepted", nb, 6);
    check("bp_count", n_out, 6);
    check("bp_last", last_t, 10);

    // Reset with two beats in flight.
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    in_valid = 1'b1; in_data = 128'h0123456789ABCDEF; in_inv = 1'b0;
    step();
    in_data = 128'hFEDCBA9876543210; in_inv = 1'b1;
    step();
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", in_ready, 1'b0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_data", out_data, '0);
    check("mid_rst_inv", out_inv, 1'b0);
    check("mid_rst_ready1", in_ready, 1'b1);
    step();
    out_ready = 1'b1;
    repeat (6) step();
    @(negedge clk);
    check("drain_a", q_a.size(), 0);
    check("drain_b", q_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sub_bytes_pipe.md
Name: sub_bytes_pipe

Overview:
- Parametrised, pipelined AES SubBytes engine: LANES independent byte lanes per beat.
- Each beat is selectable per transfer between forward S-box (encrypt) and inverse S-box (decrypt).
- Elastic valid/ready pipeline, one beat per cycle sustained.
- Sits between the AddRoundKey/ShiftRows datapath and the MixColumns stage of the round core; also reused by the key-expansion SubWord path with LANES=4.

Parameters:
- LANES, 16, byte lanes per beat (1..16).
- PIPE_STAGES, 2, register stages, 1 or 2. Other values are illegal; elaboration fails.
- SUPPORT_INV, 1, 1 = inverse table present; 0 = forward only, in_inv ignored.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept beat this cycle.
- in_data  input  8*LANES  lane i = in_data[8i+7:8i].
- in_inv  input  1  1 = inverse S-box for this beat.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts.
- out_data  output  8*LANES  substituted bytes, same lane order.
- out_inv  output  1  in_inv of the beat, carried alongside; forced 0 when SUPPORT_INV=0.

Behaviour:
- Transfer rules: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Stage structure: stages k = 0..PIPE_STAGES-1, each holding v[k], data and inv.
  - PIPE_STAGES=2: stage 0 registers raw bytes and inv; stage 1 registers the lookup result.
  - PIPE_STAGES=1: lookup is combinational from in_data; its result is registered in the single stage.
- Advance logic:
  - adv[last] = !v[last] || out_ready.
  - adv[k] = !v[k] || adv[k+1].
  - in_ready = adv[0].
  - The ready chain is combinational; there is no combinational path in_valid -> out_valid.
- Stage update: when adv[k], stage k loads from the previous stage (or from the input), and v[k] takes the upstream valid. When !adv[k], stage k holds data, inv and v unchanged.
- Outputs: out_valid = v[last], out_data/out_inv = last-stage registers.
- Latency: exactly PIPE_STAGES cycles from input transfer to out_valid, with no stall.
- Throughput: 1 beat/cycle while out_ready=1. Up to PIPE_STAGES beats are buffered under backpressure, and beat order is preserved.
- Stability: while out_valid && !out_ready, out_data and out_inv are held stable.
- Lookup: per lane, forward S-box (FIPS-197 Fig. 7) when inv=0, inverse S-box (FIPS-197 Fig. 14) when inv=1. Both tables are total over 0x00..0xFF; there is no default/X case.
- SUPPORT_INV=0: the inverse table is not instantiated, all beats use the forward table, and out_inv=0.
- Simultaneous events: with the pipeline full, a cycle with out_ready=1 and in_valid=1 both retires one beat and accepts one beat. There are no bubbles.
- Reset:
  - rst=1 clears all v[k] to 0, so out_valid=0.
  - rst=1 forces in_ready=0 for that cycle.
  - Data/inv registers reset to 0, so out_data=0 and out_inv=0.
  - Reset mid-operation discards all in-flight beats. No beat accepted before reset appears afterwards.
  - in_ready returns to 1 on the first cycle after rst deasserts.
- Nothing in the block is wider than 8 bits per lane. There is no cross-lane interaction.

Decomposition:
- Package aes_pkg holds:
  - AES_SBOX_FWD and AES_SBOX_INV 256x8 constant tables.
  - BYTE_W=8.
  - A function for each table lookup.
- Sub-module aes_sbox_lane is natural: combinational, 8-bit in, inv select, 8-bit out, with a SUPPORT_INV parameter. It is instantiated LANES times via generate.
- The pipeline control (v/adv chain) stays in sub_bytes_pipe.

Test Plan:
- Forward beat: LANES=4, in_data=0xFF53_0100 (lanes 0..3 = 00,01,53,FF), in_inv=0 -> out_data=0x16ED_7C63 exactly 2 cycles later, out_inv=0.
- Inverse beat: in_data=0x16ED_7C63, in_inv=1 -> out_data=0xFF53_0100, out_inv=1. Interleaving fwd/inv on consecutive cycles gives the correct per-beat table.
- Exhaustive round-trip: LANES=16, feed all 256 byte values forward, then feed the results back inverse. Every output equals its original byte, and forward 0x00->0x63, 0xFF->0x16, 0x52 inverse-maps from 0x00.
- Backpressure: stream 6 beats with out_ready=0 for cycles 3..5.
  - in_ready drops once 2 beats are held.
  - out_data is stable while stalled.
  - All 6 beats emerge in order, none lost or duplicated.
  - After release, 1 beat/cycle resumes.
- Reset mid-stream: rst=1 for 1 cycle with 2 beats in flight -> out_valid=0 and out_data=0 the next cycle. Neither beat ever appears. in_ready=1 the cycle after rst falls.
- PIPE_STAGES=1, SUPPORT_INV=0: latency is 1 cycle, in_inv=1 still yields forward substitution (0x00->0x63), and out_inv=0.
